// File: rtl/mic_pkg.sv
// Shared constants for the microphone sound-in path.
package mic_pkg;
    localparam int MIC_WORD_W     = 32;
    localparam int ULAW_W         = 8;
    localparam int DEF_DEPTH_LOG2 = 3;
    localparam int DEF_BURST      = 4;

    // Level counter needs one extra bit to represent a completely full FIFO.
    function automatic int level_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction
endpackage

// File: rtl/sync_fifo_sa.sv
// Single-clock show-ahead FIFO with a registered head word that holds its value when empty.
module sync_fifo_sa #(
    parameter int W          = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [W-1:0]          wdata_i,
    output logic [W-1:0]          rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic [DEPTH_LOG2:0]   level_nxt_o
);
    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [W-1:0]            mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q, level_d;
    logic [W-1:0]            rdata_q, rdata_d;
    logic                    do_push, do_pop;

    assign empty_o     = (level_q == '0);
    assign full_o      = (level_q == FULL_LVL);
    assign do_pop      = pop_i && !empty_o;
    assign do_push     = push_i && (!full_o || do_pop);
    assign rdata_o     = rdata_q;
    assign level_o     = level_q;
    assign level_nxt_o = level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rdata_d  = rdata_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
        // Head slot being written this cycle is not in memory yet: bypass it.
        if (level_d != '0)
            rdata_d = (do_push && wr_ptr_q == rd_ptr_d) ? wdata_i : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule

// File: rtl/mic_sound_in_fifo.sv
// Mic capture word FIFO feeding the sound-in DMA engine: valid/retrieved upstream,
// burst-request / per-word-ack downstream, sticky stall flag when upstream waits on full.
module mic_sound_in_fifo
    import mic_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int BURST      = DEF_BURST
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [MIC_WORD_W-1:0]           mic_data,
    input  logic                            mic_data_valid,
    output logic                            mic_data_retrieved,
    input  logic                            fifo_clear,
    input  logic                            flush,
    output logic                            dma_req,
    output logic [MIC_WORD_W-1:0]           dma_data,
    input  logic                            dma_ack,
    output logic [level_w(DEPTH_LOG2)-1:0]  level,
    output logic                            stall_flag,
    input  logic                            flag_clear
);
    logic                            retrieved_q, retrieved_d;
    logic                            dma_req_q, dma_req_d;
    logic                            stall_q, stall_d;
    logic                            full, empty, pop, capture, push, stall_set;
    logic [level_w(DEPTH_LOG2)-1:0]  level_nxt;

    assign pop       = dma_ack && !empty;
    // Retrieved pulse blocks capture so the still-high valid is not written twice.
    assign capture   = mic_data_valid && !retrieved_q && (!full || pop);
    assign push      = capture && !fifo_clear;
    assign stall_set = mic_data_valid && !retrieved_q && full && !pop;

    sync_fifo_sa #(.W(MIC_WORD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (fifo_clear),
        .push_i      (push),
        .pop_i       (pop),
        .wdata_i     (mic_data),
        .rdata_o     (dma_data),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level),
        .level_nxt_o (level_nxt)
    );

    always_comb begin
        retrieved_d = push;
        stall_d     = stall_set ? 1'b1 : (flag_clear ? 1'b0 : stall_q);
        if (flush) dma_req_d = (level_nxt != '0);
        else       dma_req_d = (int'(level_nxt) >= BURST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retrieved_q <= 1'b0;
            dma_req_q   <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            retrieved_q <= retrieved_d;
            dma_req_q   <= dma_req_d;
            stall_q     <= stall_d;
        end
    end

    assign mic_data_retrieved = retrieved_q;
    assign dma_req            = dma_req_q;
    assign stall_flag         = stall_q;
endmodule

// File: tb/tb_mic_sound_in_fifo.sv
// Bench for mic_sound_in_fifo: directed vector table, corner sequences, random traffic vs queue model.
module tb_mic_sound_in_fifo;
    localparam int DEPTH = 8;
    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mic_data;
    logic        mic_data_valid, mic_data_retrieved;
    logic        fifo_clear, flush, dma_req, dma_ack, stall_flag, flag_clear;
    logic [31:0] dma_data;
    logic [3:0]  level;

    mic_sound_in_fifo #(.DEPTH_LOG2(3), .BURST(BURST)) dut (
        .clk(clk), .rst(rst), .mic_data(mic_data), .mic_data_valid(mic_data_valid),
        .mic_data_retrieved(mic_data_retrieved), .fifo_clear(fifo_clear), .flush(flush),
        .dma_req(dma_req), .dma_data(dma_data), .dma_ack(dma_ack), .level(level),
        .stall_flag(stall_flag), .flag_clear(flag_clear)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // Reference model: a word queue plus the few observable flags.
    logic [31:0] q[$];
    logic        m_ret, m_stall, m_req;
    logic [31:0] m_head;

    typedef struct {
        logic v; logic [31:0] d; logic ack, fl, clr, fc;
        logic e_ret; int e_lvl; logic e_req, e_stall; logic [31:0] e_data;
    } vec_t;
    vec_t tbl[18];

    function automatic vec_t mk(int v, int unsigned d, int ack, int fl, int clr, int fc,
                                int er, int el, int erq, int est, int unsigned ed);
        vec_t t;
        t.v = (v != 0); t.d = d; t.ack = (ack != 0); t.fl = (fl != 0);
        t.clr = (clr != 0); t.fc = (fc != 0); t.e_ret = (er != 0); t.e_lvl = el;
        t.e_req = (erq != 0); t.e_stall = (est != 0); t.e_data = ed;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete(); m_ret = 1'b0; m_stall = 1'b0; m_req = 1'b0; m_head = '0;
    endtask

    // Advance model by one edge from the current inputs, clock, compare all outputs.
    task automatic step();
        bit full, pop, cap;
        full = (q.size() == DEPTH);
        pop  = dma_ack && (q.size() > 0);
        cap  = mic_data_valid && !m_ret && (!full || pop);
        if (mic_data_valid && !m_ret && full && !pop) m_stall = 1'b1;
        else if (flag_clear)                          m_stall = 1'b0;
        if (fifo_clear) begin
            q.delete(); m_ret = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (cap) q.push_back(mic_data);
            m_ret = cap;
        end
        if (q.size() > 0) m_head = q[0];
        m_req = flush ? (q.size() > 0) : (q.size() >= BURST);
        @(posedge clk); #1;
        chk("retrieved", 32'(mic_data_retrieved), 32'(m_ret));
        chk("level",     32'(level),              32'(q.size()));
        chk("dma_req",   32'(dma_req),            32'(m_req));
        chk("stall",     32'(stall_flag),         32'(m_stall));
        chk("dma_data",  dma_data,                m_head);
    endtask

    // Upstream behaviour: hold valid until one cycle after the retrieved pulse.
    task automatic push_word(input logic [31:0] d);
        bit got = 0;
        mic_data_valid = 1'b1; mic_data = d;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = mic_data_retrieved;
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL push_timeout: got no pulse expected pulse for %0h", d);
        end
        step();
        mic_data_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mic_data = '0; mic_data_valid = 0; fifo_clear = 0; flush = 0;
        dma_ack = 0; flag_clear = 0;
        model_reset();
        tbl[0]  = mk(1, 32'hA1B2C3D4, 0,0,0,0, 1,1,0,0, 32'hA1B2C3D4);
        tbl[1]  = mk(1, 32'hA1B2C3D4, 0,0,0,0, 0,1,0,0, 32'hA1B2C3D4);
        tbl[2]  = mk(0, 0,            1,0,0,0, 0,0,0,0, 32'hA1B2C3D4);
        tbl[3]  = mk(1, 1, 0,0,0,0, 1,1,0,0, 1);
        tbl[4]  = mk(1, 2, 0,0,0,0, 0,1,0,0, 1);
        tbl[5]  = mk(1, 2, 0,0,0,0, 1,2,0,0, 1);
        tbl[6]  = mk(1, 3, 0,0,0,0, 0,2,0,0, 1);
        tbl[7]  = mk(1, 3, 0,0,0,0, 1,3,0,0, 1);
        tbl[8]  = mk(1, 4, 0,0,0,0, 0,3,0,0, 1);
        tbl[9]  = mk(1, 4, 0,0,0,0, 1,4,1,0, 1);
        tbl[10] = mk(0, 0, 1,0,0,0, 0,3,0,0, 2);
        tbl[11] = mk(0, 0, 1,0,0,0, 0,2,0,0, 3);
        tbl[12] = mk(0, 0, 1,0,0,0, 0,1,0,0, 4);
        tbl[13] = mk(0, 0, 1,0,0,0, 0,0,0,0, 4);
        tbl[14] = mk(0, 0, 1,0,0,0, 0,0,0,0, 4);
        tbl[15] = mk(1, 5, 0,1,0,0, 1,1,1,0, 5);
        tbl[16] = mk(0, 0, 0,1,0,0, 0,1,1,0, 5);
        tbl[17] = mk(0, 0, 1,1,0,0, 0,0,0,0, 5);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ret",   32'(mic_data_retrieved), 0);
        chk("rst_level", 32'(level),              0);
        chk("rst_req",   32'(dma_req),            0);
        chk("rst_stall", 32'(stall_flag),         0);
        chk("rst_data",  dma_data,                0);
        @(negedge clk); rst = 1'b0;

        foreach (tbl[i]) begin
            mic_data_valid = tbl[i].v; mic_data = tbl[i].d; dma_ack = tbl[i].ack;
            flush = tbl[i].fl; fifo_clear = tbl[i].clr; flag_clear = tbl[i].fc;
            step();
            chk($sformatf("v%0d_ret", i),   32'(mic_data_retrieved), 32'(tbl[i].e_ret));
            chk($sformatf("v%0d_lvl", i),   32'(level),              32'(tbl[i].e_lvl));
            chk($sformatf("v%0d_req", i),   32'(dma_req),            32'(tbl[i].e_req));
            chk($sformatf("v%0d_stall", i), 32'(stall_flag),         32'(tbl[i].e_stall));
            chk($sformatf("v%0d_data", i),  dma_data,                tbl[i].e_data);
        end
        mic_data_valid = 0; dma_ack = 0; flush = 0; fifo_clear = 0; flag_clear = 0;

        // Full stall, then a pop lets the waiting word in while full.
        for (int i = 0; i < DEPTH; i++) push_word(32'h100 + i);
        chk("full_level", 32'(level), 8);
        mic_data_valid = 1'b1; mic_data = 32'hDEADBEEF;
        repeat (3) step();
        chk("full_no_pulse", 32'(mic_data_retrieved), 0);
        chk("full_stall",    32'(stall_flag),         1);
        dma_ack = 1'b1; step(); dma_ack = 1'b0;
        chk("full_cap_pulse", 32'(mic_data_retrieved), 1);
        chk("full_cap_level", 32'(level),              8);
        chk("full_cap_head",  dma_data,                32'h101);
        step(); mic_data_valid = 1'b0;
        flag_clear = 1'b1; step(); flag_clear = 1'b0;
        chk("flag_cleared", 32'(stall_flag), 0);
        dma_ack = 1'b1; repeat (9) step(); dma_ack = 1'b0;
        chk("drained_data", dma_data, 32'hDEADBEEF);

        // Clear with level 5, then a clear that discards a same-cycle capture.
        for (int i = 0; i < 5; i++) push_word(32'h300 + i);
        chk("pre_clear_req", 32'(dma_req), 1);
        fifo_clear = 1'b1; mic_data_valid = 1'b1; mic_data = 32'h55;
        step(); fifo_clear = 1'b0;
        chk("clear_level", 32'(level), 0);
        chk("clear_req",   32'(dma_req), 0);
        chk("clear_nopulse", 32'(mic_data_retrieved), 0);
        step(); step(); mic_data_valid = 1'b0;
        chk("recap_level", 32'(level), 1);
        chk("recap_data",  dma_data,   32'h55);

        // Reset lands during the retrieved pulse.
        mic_data_valid = 1'b1; mic_data = 32'h77;
        step();
        chk("pre_rst_pulse", 32'(mic_data_retrieved), 1);
        rst = 1'b1; #1;
        chk("rst_cut_ret",   32'(mic_data_retrieved), 0);
        chk("rst_cut_level", 32'(level),              0);
        chk("rst_cut_data",  dma_data,                0);
        chk("rst_cut_req",   32'(dma_req),            0);
        model_reset();
        @(negedge clk); rst = 1'b0;
        step();
        chk("rst_recap", 32'(mic_data_retrieved), 1);
        step(); mic_data_valid = 1'b0;
        dma_ack = 1'b1; step();

        // Pointer wrap: sequential stream with acks held high.
        for (int i = 0; i < 20; i++) push_word(32'h200 + i);
        step(); dma_ack = 1'b0;
        chk("wrap_level", 32'(level), 0);
        chk("wrap_last",  dma_data,   32'h213);

        // Random traffic against the queue model.
        begin
            bit prev_pulse = 0;
            for (int c = 0; c < 600; c++) begin
                dma_ack    = ($urandom_range(0, 99) < 45);
                flush      = ($urandom_range(0, 99) < 20);
                fifo_clear = ($urandom_range(0, 99) < 3);
                flag_clear = ($urandom_range(0, 99) < 5);
                step();
                if (prev_pulse) begin
                    mic_data_valid = $urandom_range(0, 1);
                    mic_data = $urandom;
                end else if (!mic_data_valid && $urandom_range(0, 2) == 0) begin
                    mic_data_valid = 1'b1;
                    mic_data = $urandom;
                end
                prev_pulse = mic_data_retrieved;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
